// File: rtl/delay_sram_responder_pkg.sv
// Shared constants for the delay-line SRAM responder: state encodings,
// default wait-cycle counts and strobe bit positions.
package delay_sram_responder_pkg;

  localparam logic [2:0] DSR_STATE_IDLE     = 3'd0;
  localparam logic [2:0] DSR_STATE_RD_WAIT  = 3'd1;
  localparam logic [2:0] DSR_STATE_WR_SETUP = 3'd2;
  localparam logic [2:0] DSR_STATE_WR_PULSE = 3'd3;
  localparam logic [2:0] DSR_STATE_WR_HOLD  = 3'd4;
  localparam logic [2:0] DSR_STATE_DONE     = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE     = DSR_STATE_IDLE,
    S_RD_WAIT  = DSR_STATE_RD_WAIT,
    S_WR_SETUP = DSR_STATE_WR_SETUP,
    S_WR_PULSE = DSR_STATE_WR_PULSE,
    S_WR_HOLD  = DSR_STATE_WR_HOLD,
    S_DONE     = DSR_STATE_DONE
  } dsr_state_e;

  localparam int DSR_READ_WAIT_DEFAULT  = 2;
  localparam int DSR_WRITE_WAIT_DEFAULT = 2;

  // Strobe vector layout {ce_n, oe_n, we_n}; all deasserted when idle.
  localparam logic [2:0] DSR_STROBE_IDLE = 3'b111;
  localparam int DSR_CE = 2;
  localparam int DSR_OE = 1;
  localparam int DSR_WE = 0;

  function automatic int dsr_cnt_w(input int max_val);
    return ($clog2(max_val + 1) < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/delay_sram_responder_if.sv
// Request/ready handshake between the delay buffer manager (master) and
// the SRAM responder (slave).
interface delay_sram_responder_if #(
  parameter int data_width      = 16,
  parameter int sram_addr_width = 12
);
  logic                       req_sram_read;
  logic                       req_sram_write;
  logic [sram_addr_width-1:0] req_sram_read_addr;
  logic [sram_addr_width-1:0] req_sram_write_addr;
  logic [data_width-1:0]      data_to_sram;
  logic                       sram_read_ready;
  logic                       sram_write_ready;
  logic [data_width-1:0]      data_from_sram;
  logic                       sram_read_invalid;
  logic                       sram_write_invalid;

  modport master (
    output req_sram_read, req_sram_write, req_sram_read_addr,
           req_sram_write_addr, data_to_sram,
    input  sram_read_ready, sram_write_ready, data_from_sram,
           sram_read_invalid, sram_write_invalid
  );

  modport slave (
    input  req_sram_read, req_sram_write, req_sram_read_addr,
           req_sram_write_addr, data_to_sram,
    output sram_read_ready, sram_write_ready, data_from_sram,
           sram_read_invalid, sram_write_invalid
  );
endinterface

// File: rtl/delay_sram_responder_timer.sv
// sram_wait_timer: loadable down-counter with a zero flag, shared by the
// read and write wait states.
module sram_wait_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                    cnt_d = load_val;
    else if (dec && !zero)       cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/delay_sram_responder.sv
// SRAM-side responder: turns level-held read/write requests into timed
// async-SRAM cycles and answers with one-cycle ready/invalid pulses.
module delay_sram_responder
  import delay_sram_responder_pkg::*;
#(
  parameter int data_width        = 16,
  parameter int sram_addr_width   = 12,
  parameter int sram_capacity     = 8096,
  parameter int read_wait_cycles  = DSR_READ_WAIT_DEFAULT,
  parameter int write_wait_cycles = DSR_WRITE_WAIT_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  delay_sram_responder_if.slave      bus,
  output logic [sram_addr_width-1:0] sram_addr,
  output logic [data_width-1:0]      sram_dq_out,
  output logic                       sram_dq_oe,
  input  logic [data_width-1:0]      sram_dq_in,
  output logic                       sram_ce_n,
  output logic                       sram_oe_n,
  output logic                       sram_we_n
);
  localparam int AW    = sram_addr_width;
  localparam int MAX_W = (read_wait_cycles > write_wait_cycles) ? read_wait_cycles : write_wait_cycles;
  localparam int CNT_W = dsr_cnt_w(MAX_W);
  // A capacity covering the whole address space can never flag invalid.
  localparam bit        CAP_ALL = (sram_capacity >= (1 << sram_addr_width));
  localparam logic [AW:0] CAP_L = CAP_ALL ? '1 : (AW+1)'(sram_capacity);

  dsr_state_e            state_q, state_d;
  logic                  srv_wr_q, srv_wr_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [data_width-1:0] dq_out_q, dq_out_d, rdata_q, rdata_d;
  logic                  dq_oe_q, dq_oe_d;
  logic [2:0]            strb_q, strb_d;
  logic                  rd_rdy_q, rd_rdy_d, wr_rdy_q, wr_rdy_d;
  logic                  rd_inv_q, rd_inv_d, wr_inv_q, wr_inv_d;
  logic                  tmr_load, tmr_dec, tmr_zero;
  logic [CNT_W-1:0]      tmr_val;
  logic                  rd_bad, wr_bad, srv_req;

  assign rd_bad  = !CAP_ALL && ({1'b0, bus.req_sram_read_addr}  >= CAP_L);
  assign wr_bad  = !CAP_ALL && ({1'b0, bus.req_sram_write_addr} >= CAP_L);
  assign srv_req = srv_wr_q ? bus.req_sram_write : bus.req_sram_read;

  sram_wait_timer #(.CNT_W(CNT_W)) u_timer (
    .clk(clk), .reset(reset), .load(tmr_load), .load_val(tmr_val),
    .dec(tmr_dec), .zero(tmr_zero)
  );

  always_comb begin
    state_d  = state_q;  srv_wr_d = srv_wr_q; addr_d  = addr_q;
    dq_out_d = dq_out_q; dq_oe_d  = dq_oe_q;  strb_d  = strb_q;
    rdata_d  = rdata_q;
    rd_rdy_d = 1'b0; wr_rdy_d = 1'b0; rd_inv_d = 1'b0; wr_inv_d = 1'b0;
    tmr_load = 1'b0; tmr_dec  = 1'b0; tmr_val  = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_sram_write) begin
          srv_wr_d = 1'b1;
          if (wr_bad) begin
            wr_inv_d = 1'b1;
            state_d  = S_DONE;
          end else begin
            addr_d         = bus.req_sram_write_addr;
            dq_out_d       = bus.data_to_sram;
            dq_oe_d        = 1'b1;
            strb_d[DSR_CE] = 1'b0;
            state_d        = S_WR_SETUP;
          end
        end else if (bus.req_sram_read) begin
          srv_wr_d = 1'b0;
          if (rd_bad) begin
            rd_inv_d = 1'b1;
            state_d  = S_DONE;
          end else begin
            addr_d         = bus.req_sram_read_addr;
            strb_d[DSR_CE] = 1'b0;
            strb_d[DSR_OE] = 1'b0;
            tmr_load       = 1'b1;
            tmr_val        = CNT_W'(read_wait_cycles - 1);
            state_d        = S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        if (tmr_zero) begin
          rdata_d  = sram_dq_in;
          strb_d   = DSR_STROBE_IDLE;
          rd_rdy_d = 1'b1;
          state_d  = S_DONE;
        end else tmr_dec = 1'b1;
      end
      S_WR_SETUP: begin
        strb_d[DSR_WE] = 1'b0;
        tmr_load       = 1'b1;
        tmr_val        = CNT_W'(write_wait_cycles - 1);
        state_d        = S_WR_PULSE;
      end
      S_WR_PULSE: begin
        if (tmr_zero) begin
          strb_d[DSR_WE] = 1'b1;
          state_d        = S_WR_HOLD;
        end else tmr_dec = 1'b1;
      end
      S_WR_HOLD: begin
        dq_oe_d        = 1'b0;
        strb_d[DSR_CE] = 1'b1;
        wr_rdy_d       = 1'b1;
        state_d        = S_DONE;
      end
      // Wait for the requester to drop the serviced line; doubles as bus turnaround.
      S_DONE:  if (!srv_req) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE; srv_wr_q <= 1'b0; addr_q  <= '0;
      dq_out_q <= '0;     dq_oe_q  <= 1'b0; strb_q  <= DSR_STROBE_IDLE;
      rdata_q  <= '0;
      rd_rdy_q <= 1'b0; wr_rdy_q <= 1'b0; rd_inv_q <= 1'b0; wr_inv_q <= 1'b0;
    end else begin
      state_q  <= state_d;  srv_wr_q <= srv_wr_d; addr_q  <= addr_d;
      dq_out_q <= dq_out_d; dq_oe_q  <= dq_oe_d;  strb_q  <= strb_d;
      rdata_q  <= rdata_d;
      rd_rdy_q <= rd_rdy_d; wr_rdy_q <= wr_rdy_d; rd_inv_q <= rd_inv_d; wr_inv_q <= wr_inv_d;
    end
  end

  assign sram_addr              = addr_q;
  assign sram_dq_out            = dq_out_q;
  assign sram_dq_oe             = dq_oe_q;
  assign sram_ce_n              = strb_q[DSR_CE];
  assign sram_oe_n              = strb_q[DSR_OE];
  assign sram_we_n              = strb_q[DSR_WE];
  assign bus.data_from_sram     = rdata_q;
  assign bus.sram_read_ready    = rd_rdy_q;
  assign bus.sram_write_ready   = wr_rdy_q;
  assign bus.sram_read_invalid  = rd_inv_q;
  assign bus.sram_write_invalid = wr_inv_q;
endmodule

// File: tb/tb_delay_sram_responder.sv
// Directed bench for delay_sram_responder with an async SRAM model and a
// read/write scoreboard checked when the ready pulses appear.
module tb_delay_sram_responder;
  localparam int DW  = 16;
  localparam int AW  = 12;
  localparam int CAP = 4000;  // below 2^AW so out-of-range addresses exist

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  delay_sram_responder_if #(.data_width(DW), .sram_addr_width(AW)) bus ();
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_dq_out, sram_dq_in;
  logic          sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

  delay_sram_responder #(
    .data_width(DW), .sram_addr_width(AW), .sram_capacity(CAP),
    .read_wait_cycles(2), .write_wait_cycles(2)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n)
  );

  // Async SRAM: latches on the rising edge of we_n while selected.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge sram_we_n) if (!sram_ce_n && sram_dq_oe) mem[sram_addr] <= sram_dq_out;
  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : '0;

  int passed = 0, failed = 0, total = 0;
  int n_we, n_oe, n_ce, n_rrdy, n_wrdy, n_rinv, n_winv, n_unstable;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_data = '0;
  logic [DW-1:0] rd_q [$];
  logic [AW-1:0] wa_q [$];
  logic [DW-1:0] wd_q [$];
  logic [DW-1:0] gold [int];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!sram_we_n) n_we++;
    if (!sram_oe_n) n_oe++;
    if (!sram_ce_n) n_ce++;
    if (bus.sram_read_invalid)  n_rinv++;
    if (bus.sram_write_invalid) n_winv++;
    if (!sram_ce_n && sram_dq_oe && (sram_addr !== exp_addr || sram_dq_out !== exp_data)) n_unstable++;
    if (bus.sram_read_ready) begin
      n_rrdy++;
      chk("rd_sb_nonempty", 32'(rd_q.size() > 0), 1);
      if (rd_q.size() > 0) chk("rd_data", bus.data_from_sram, rd_q.pop_front());
    end
    if (bus.sram_write_ready) begin
      n_wrdy++;
      chk("wr_sb_nonempty", 32'(wa_q.size() > 0), 1);
      if (wa_q.size() > 0) chk("wr_mem", mem[wa_q.pop_front()], wd_q.pop_front());
    end
  end

  task automatic clr();
    n_we = 0; n_oe = 0; n_ce = 0; n_rrdy = 0; n_wrdy = 0;
    n_rinv = 0; n_winv = 0; n_unstable = 0;
  endtask

  // sel: 0 read_ready, 1 write_ready, 2 read_invalid, 3 write_invalid
  task automatic wait_pulse(input string tag, input int sel, input int exp_lat);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      case (sel)
        0:       seen = bus.sram_read_ready;
        1:       seen = bus.sram_write_ready;
        2:       seen = bus.sram_read_invalid;
        default: seen = bus.sram_write_invalid;
      endcase
    end
    chk({tag, "_seen"}, 32'(seen), 1);
    chk({tag, "_lat"}, n, exp_lat);
  endtask

  // Requester drops its line one cycle after the pulse, then idles a bit.
  task automatic finish_req();
    @(negedge clk);
    bus.req_sram_write = 1'b0;
    bus.req_sram_read  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit valid, input int lat);
    clr();
    exp_addr = a; exp_data = d;
    if (valid) begin
      wa_q.push_back(a); wd_q.push_back(d); gold[int'(a)] = d;
    end
    bus.req_sram_write_addr = a;
    bus.data_to_sram        = d;
    bus.req_sram_write      = 1'b1;
    wait_pulse(valid ? "wr" : "wr_inv", valid ? 1 : 3, lat);
    finish_req();
  endtask

  task automatic do_read(input logic [AW-1:0] a, input bit valid, input int lat);
    clr();
    if (valid) rd_q.push_back(gold[int'(a)]);
    bus.req_sram_read_addr = a;
    bus.req_sram_read      = 1'b1;
    wait_pulse(valid ? "rd" : "rd_inv", valid ? 0 : 2, lat);
    finish_req();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_sram_read = 1'b0; bus.req_sram_write = 1'b0;
    bus.req_sram_read_addr = '0; bus.req_sram_write_addr = '0; bus.data_to_sram = '0;
    #1 reset = 1'b1;
    #3;
    chk("rst_ce_n", sram_ce_n, 1);
    chk("rst_oe_n", sram_oe_n, 1);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_dq_oe", sram_dq_oe, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_dq_out", sram_dq_out, 0);
    chk("rst_rdata", bus.data_from_sram, 0);
    chk("rst_pulses", {bus.sram_read_ready, bus.sram_write_ready,
                       bus.sram_read_invalid, bus.sram_write_invalid}, 0);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);

    // Basic write: setup + 2 we_n cycles + hold, no retrigger while req held.
    do_write(12'h005, 16'h1234, 1'b1, 5);
    chk("wr_we_cycles", n_we, 2);
    chk("wr_ce_cycles", n_ce, 4);
    chk("wr_ready_cnt", n_wrdy, 1);
    chk("wr_unstable", n_unstable, 0);
    chk("wr_no_oe", n_oe, 0);

    do_read(12'h005, 1'b1, 3);
    chk("rd_oe_cycles", n_oe, 2);
    chk("rd_ce_cycles", n_ce, 2);
    chk("rd_ready_cnt", n_rrdy, 1);
    chk("rd_no_we", n_we, 0);
    chk("rd_hold", bus.data_from_sram, 16'h1234);

    // Last in-range address.
    do_write(12'(CAP - 1), 16'h5A5A, 1'b1, 5);
    do_read(12'(CAP - 1), 1'b1, 3);

    // Address 8096 wraps to 0xFA0 == CAP on a 12-bit bus.
    do_write(12'hFA0, 16'hDEAD, 1'b0, 1);
    chk("winv_ce", n_ce, 0);
    chk("winv_we", n_we, 0);
    chk("winv_cnt", n_winv, 1);
    chk("winv_no_ready", n_wrdy, 0);
    do_read(12'hFFF, 1'b0, 1);
    chk("rinv_ce", n_ce, 0);
    chk("rinv_oe", n_oe, 0);
    chk("rinv_cnt", n_rinv, 1);
    chk("rinv_no_ready", n_rrdy, 0);
    chk("rinv_rdata_kept", bus.data_from_sram, 16'h5A5A);

    // Simultaneous read and write to the same address: write goes first.
    clr();
    exp_addr = 12'h0AA; exp_data = 16'hBEEF;
    wa_q.push_back(12'h0AA); wd_q.push_back(16'hBEEF); gold[12'h0AA] = 16'hBEEF;
    rd_q.push_back(16'hBEEF);
    bus.req_sram_write_addr = 12'h0AA; bus.data_to_sram = 16'hBEEF;
    bus.req_sram_read_addr  = 12'h0AA;
    bus.req_sram_write = 1'b1; bus.req_sram_read = 1'b1;
    wait_pulse("sim_wr", 1, 5);
    chk("sim_no_rd_before_wr", n_oe, 0);
    @(negedge clk) bus.req_sram_write = 1'b0;
    wait_pulse("sim_rd", 0, 4);
    finish_req();
    chk("sim_wr_cnt", n_wrdy, 1);
    chk("sim_rd_cnt", n_rrdy, 1);
    chk("sim_we_cycles", n_we, 2);

    // Async reset while we_n is low aborts the write without a ready pulse.
    clr();
    exp_addr = 12'h010; exp_data = 16'hCAFE;
    bus.req_sram_write_addr = 12'h010; bus.data_to_sram = 16'hCAFE;
    bus.req_sram_write = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mid_we_low", sram_we_n, 0);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_we_n", sram_we_n, 1);
    chk("rst_mid_ce_n", sram_ce_n, 1);
    chk("rst_mid_dq_oe", sram_dq_oe, 0);
    bus.req_sram_write = 1'b0;
    @(negedge clk) reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid_no_ready", n_wrdy, 0);

    do_write(12'h010, 16'h1111, 1'b1, 5);
    do_read(12'h010, 1'b1, 3);
    chk("post_rst_rdata", bus.data_from_sram, 16'h1111);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
